execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the 5-stage pipeline, between the D/X register and the X/M register. Consumes the hazard unit's forwarding selects and bubble request, picks each ALU operand from the register file, the X/M result or the M/W write-back value, computes the result and registers it into the X/M pipeline register. Multiply is an optional multi-cycle operation; while it runs, the block holds upstream with a busy stall.

## Interface
- `DW`, default 32: datapath width.
- `RW`, default 5: register index width.
- `MUL_CYC`, default 8: multiply iterations; must divide `DW`; each iteration consumes `DW/MUL_CYC` multiplier bits.

Ports:
- `clk` input 1: clock.
- `n_reset` input 1: synchronous active-low reset.
- `valid_dx` input 1: D/X holds a real instruction.
- `op_dx` input 4: ALU op. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed), 8 MOV (A), 9 MUL; others are illegal.
- `rd_dx` input RW: destination index.
- `writes_rf_dx` input 1: instruction writes the RF.
- `rs_val` input DW: RF read of rs_imm (operand A source).
- `rd_val` input DW: RF read of rd (operand B source).
- `fwd_a`, `fwd_b` input 2 each: operand select. 00 RF, 01 `wb_data`, 10 `xm_result`, 11 treated as 00.
- `wb_data` input DW: M/W write-back value.
- `bubble` input 1: load-use hazard; load a NOP into X/M this cycle.
- `mem_stall` input 1: downstream hold; freeze X/M and all internal state.
- `xm_valid` output 1: X/M holds a real instruction.
- `xm_result` output DW: registered result; also the forward source.
- `xm_rd` output RW: registered destination index.
- `xm_writes_rf` output 1: registered write enable; forced 0 when `xm_valid`=0.
- `x_busy` output 1: multiply in progress; upstream must hold D/X.
- `illegal_op` output 1: one-cycle pulse, registered with the offending X/M entry.

## Operation
- Operand A = mux(`fwd_a`) over `rs_val`/`wb_data`/`xm_result`; operand B likewise with `fwd_b`/`rd_val`. The muxes are combinational, and forwarding uses the current `xm_result` register.
- Shifts use B[log2(DW)-1:0] as the amount. ADD/SUB wrap modulo 2^DW. SLT gives 1 or 0 zero-extended. MUL returns the low DW bits of the product.
- State machine IDLE / MUL / DONE:
  - IDLE: single-cycle ops load X/M at the next edge. MUL latches A and B, clears the accumulator, sets the count to `MUL_CYC`, goes to MUL and raises `x_busy`; X/M gets a NOP.
  - MUL: each non-stalled cycle does one shift-add step and decrements the count. At count 1 the next state is DONE.
  - DONE: `x_busy` drops. X/M loads the product with the latched rd and write enable. Return to IDLE.
- Priority per edge: `n_reset` > `mem_stall` (hold everything) > `bubble` (NOP into X/M; a multiply in MUL keeps iterating) > normal.
- A `bubble` in IDLE while `op_dx`=MUL means the multiply does not start.
- An illegal op writes a NOP-like entry: `xm_valid`=1, `xm_writes_rf`=0, `xm_result`=0, and pulses `illegal_op`.
- `valid_dx`=0 produces a NOP.

## Timing
- Reset values: `xm_valid`=0, `xm_result`=0, `xm_rd`=0, `xm_writes_rf`=0, `x_busy`=0, `illegal_op`=0, state IDLE. Reset mid-multiply aborts it with no write.
- Single-cycle op latency: 1 edge from D/X to X/M.
- MUL latency: `MUL_CYC`+2 edges from the accept edge to a valid X/M, excluding `mem_stall` cycles.
- `x_busy` is high from the cycle after the accept edge through the last MUL cycle.
- `mem_stall` freezes the count; `x_busy` is unchanged during stall.

## Configuration
- `EXEC_MUL_EN` defined: the multiplier FSM is present and behaves as above.
- `EXEC_MUL_EN` undefined: no MUL/DONE states and `x_busy` is tied 0. Op 9 is illegal (illegal-op behaviour above).

## Test plan
- Forward priority: `rs_val`=1, `wb_data`=2, `xm_result`=3, ADD with B=10, `fwd_a`=10 → `xm_result`=13; with `fwd_a`=01 → 12; with `fwd_a`=11 → 11.
- Bubble: a valid ADD with `bubble`=1 → next edge `xm_valid`=0, `xm_writes_rf`=0, `xm_result` unchanged path ignored; the following cycle the ADD completes normally.
- Multiply (`EXEC_MUL_EN`, `MUL_CYC`=8): 0xFFFF_FFFF × 3 → `x_busy` high for 8 cycles, then `xm_result`=0xFFFF_FFFD, rd and write enable preserved, total 10 edges.
- Stall mid-multiply: assert `mem_stall` for 3 cycles at iteration 4 → result unchanged, completes 3 cycles later, and X/M holds its value throughout the stall.
- Reset mid-multiply: deassert `n_reset` at iteration 2 → all outputs 0 and state IDLE on the next edge, with no X/M write afterwards.
- Arithmetic edges: SUB 0−1 → 0xFFFF_FFFF. SLT −1<0 → 1. SLL by 33 → shift of 1. Op 15 → `illegal_op` pulse with `xm_writes_rf`=0.

Source files
------------

// File: rtl/execute_stage_if.sv
// D/X-to-X/M bundle for the execute stage: decoded instruction, operands,
// forwarding/hazard controls in, X/M pipeline register and status out.
interface execute_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    logic          valid_dx;
    logic [3:0]    op_dx;
    logic [RW-1:0] rd_dx;
    logic          writes_rf_dx;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rd_val;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic [DW-1:0] wb_data;
    logic          bubble;
    logic          mem_stall;

    logic          xm_valid;
    logic [DW-1:0] xm_result;
    logic [RW-1:0] xm_rd;
    logic          xm_writes_rf;
    logic          x_busy;
    logic          illegal_op;

    modport master (
        output valid_dx, op_dx, rd_dx, writes_rf_dx, rs_val, rd_val,
        output fwd_a, fwd_b, wb_data, bubble, mem_stall,
        input  xm_valid, xm_result, xm_rd, xm_writes_rf, x_busy, illegal_op
    );

    modport slave (
        input  valid_dx, op_dx, rd_dx, writes_rf_dx, rs_val, rd_val,
        input  fwd_a, fwd_b, wb_data, bubble, mem_stall,
        output xm_valid, xm_result, xm_rd, xm_writes_rf, x_busy, illegal_op
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding muxes, single-cycle ALU and the X/M register.
// Define EXEC_MUL_EN to add the iterative shift-add multiplier (op 9) with busy stall.
module execute_stage #(
    parameter int unsigned DW      = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned MUL_CYC = 8
) (
    input logic            clk,
    input logic            n_reset,
    execute_stage_if.slave bus
);
    localparam int unsigned SW = $clog2(DW);

    localparam logic [3:0] OpAdd = 4'd0;
    localparam logic [3:0] OpSub = 4'd1;
    localparam logic [3:0] OpAnd = 4'd2;
    localparam logic [3:0] OpOr  = 4'd3;
    localparam logic [3:0] OpXor = 4'd4;
    localparam logic [3:0] OpSll = 4'd5;
    localparam logic [3:0] OpSrl = 4'd6;
    localparam logic [3:0] OpSlt = 4'd7;
    localparam logic [3:0] OpMov = 4'd8;

    logic          xm_valid_q;
    logic [DW-1:0] xm_result_q;
    logic [RW-1:0] xm_rd_q;
    logic          xm_wr_q;
    logic          illegal_q;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic          op_legal;
    logic          start_mul;

    logic          idle_valid;
    logic [DW-1:0] idle_result;
    logic [RW-1:0] idle_rd;
    logic          idle_wr;
    logic          idle_ill;

    // Select 11 falls back to the register file value.
    always_comb begin
        case (bus.fwd_a)
            2'b01:   op_a = bus.wb_data;
            2'b10:   op_a = xm_result_q;
            default: op_a = bus.rs_val;
        endcase
        case (bus.fwd_b)
            2'b01:   op_b = bus.wb_data;
            2'b10:   op_b = xm_result_q;
            default: op_b = bus.rd_val;
        endcase
    end

    always_comb begin
        alu_res  = '0;
        op_legal = 1'b1;
        case (bus.op_dx)
            OpAdd:   alu_res = op_a + op_b;
            OpSub:   alu_res = op_a - op_b;
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpSll:   alu_res = op_a << op_b[SW-1:0];
            OpSrl:   alu_res = op_a >> op_b[SW-1:0];
            OpSlt:   alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OpMov:   alu_res = op_a;
            default: op_legal = 1'b0;
        endcase
    end

    // X/M entry produced from D/X when no multiply is in flight; NOPs keep result/rd.
    always_comb begin
        idle_valid  = 1'b0;
        idle_result = xm_result_q;
        idle_rd     = xm_rd_q;
        idle_wr     = 1'b0;
        idle_ill    = 1'b0;
        if (bus.valid_dx && !bus.bubble && !start_mul) begin
            idle_valid = 1'b1;
            idle_rd    = bus.rd_dx;
            if (op_legal) begin
                idle_result = alu_res;
                idle_wr     = bus.writes_rf_dx;
            end else begin
                idle_result = '0;
                idle_ill    = 1'b1;
            end
        end
    end

`ifdef EXEC_MUL_EN
    localparam logic [3:0]  OpMul = 4'd9;
    localparam int unsigned MK    = DW / MUL_CYC;
    localparam int unsigned CW    = $clog2(MUL_CYC + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e        state_q;
    logic          busy_q;
    logic [DW-1:0] mul_a_q;
    logic [DW-1:0] mul_b_q;
    logic [DW-1:0] mul_acc_q;
    logic [DW-1:0] mul_sum;
    logic [CW-1:0] mul_cnt_q;
    logic [RW-1:0] mul_rd_q;
    logic          mul_wr_q;

    assign start_mul = bus.valid_dx && !bus.bubble && (bus.op_dx == OpMul);

    // One iteration folds MK multiplier bits into the accumulator.
    always_comb begin
        mul_sum = mul_acc_q;
        for (int k = 0; k < int'(MK); k++) begin
            if (mul_b_q[k]) mul_sum = mul_sum + (mul_a_q << k);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            xm_valid_q  <= 1'b0;
            xm_result_q <= '0;
            xm_rd_q     <= '0;
            xm_wr_q     <= 1'b0;
            illegal_q   <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_acc_q   <= '0;
            mul_cnt_q   <= '0;
            mul_rd_q    <= '0;
            mul_wr_q    <= 1'b0;
        end else if (!bus.mem_stall) begin
            unique case (state_q)
                StIdle: begin
                    xm_valid_q  <= idle_valid;
                    xm_result_q <= idle_result;
                    xm_rd_q     <= idle_rd;
                    xm_wr_q     <= idle_wr;
                    illegal_q   <= idle_ill;
                    if (start_mul) begin
                        state_q   <= StMul;
                        busy_q    <= 1'b1;
                        mul_a_q   <= op_a;
                        mul_b_q   <= op_b;
                        mul_acc_q <= '0;
                        mul_cnt_q <= CW'(MUL_CYC);
                        mul_rd_q  <= bus.rd_dx;
                        mul_wr_q  <= bus.writes_rf_dx;
                    end
                end
                StMul: begin
                    xm_valid_q <= 1'b0;
                    xm_wr_q    <= 1'b0;
                    illegal_q  <= 1'b0;
                    mul_acc_q  <= mul_sum;
                    mul_a_q    <= mul_a_q << MK;
                    mul_b_q    <= mul_b_q >> MK;
                    mul_cnt_q  <= mul_cnt_q - CW'(1);
                    if (mul_cnt_q == CW'(1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end
                end
                StDone: begin
                    // The product does not come from D/X, so a bubble cannot cancel it.
                    xm_valid_q  <= 1'b1;
                    xm_result_q <= mul_acc_q;
                    xm_rd_q     <= mul_rd_q;
                    xm_wr_q     <= mul_wr_q;
                    illegal_q   <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.x_busy = busy_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^MUL_CYC;
    assign start_mul  = 1'b0;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            xm_valid_q  <= 1'b0;
            xm_result_q <= '0;
            xm_rd_q     <= '0;
            xm_wr_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (!bus.mem_stall) begin
            xm_valid_q  <= idle_valid;
            xm_result_q <= idle_result;
            xm_rd_q     <= idle_rd;
            xm_wr_q     <= idle_wr;
            illegal_q   <= idle_ill;
        end
    end

    assign bus.x_busy = 1'b0;
`endif

    assign bus.xm_valid     = xm_valid_q;
    assign bus.xm_result    = xm_result_q;
    assign bus.xm_rd        = xm_rd_q;
    assign bus.xm_writes_rf = xm_wr_q;
    assign bus.illegal_op   = illegal_q;
endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table plus multi-cycle sequences,
// with X/M entries checked against a scoreboard queue.
module tb_execute_stage;
    localparam int unsigned DW      = 32;
    localparam int unsigned RW      = 5;
    localparam int unsigned MUL_CYC = 8;

    logic clk = 1'b0;
    logic n_reset;

    execute_stage_if #(.DW(DW), .RW(RW)) dut_if ();

    execute_stage #(.DW(DW), .RW(RW), .MUL_CYC(MUL_CYC)) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (dut_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] rs;
        logic [31:0] rdv;
        logic [31:0] wb;
        logic [4:0]  rdi;
        logic        wr;
        logic        ev;
        logic [31:0] eres;
        logic        ewr;
        logic        eill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic        ill;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic v, logic [3:0] op, logic [1:0] fa, logic [1:0] fb,
                                logic [31:0] rs, logic [31:0] rdv, logic [31:0] wb,
                                logic [4:0] rdi, logic wr, logic ev, logic [31:0] eres,
                                logic ewr, logic eill);
        vec_t t;
        t.v = v; t.op = op; t.fa = fa; t.fb = fb; t.rs = rs; t.rdv = rdv; t.wb = wb;
        t.rdi = rdi; t.wr = wr; t.ev = ev; t.eres = eres; t.ewr = ewr; t.eill = eill;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [4:0] rd, input logic wr,
                        input logic ill);
        exp_t e;
        e.res = res; e.rd = rd; e.wr = wr; e.ill = ill;
        sb.push_back(e);
    endtask

    task automatic drive(input vec_t t);
        dut_if.valid_dx     = t.v;
        dut_if.op_dx        = t.op;
        dut_if.fwd_a        = t.fa;
        dut_if.fwd_b        = t.fb;
        dut_if.rs_val       = t.rs;
        dut_if.rd_val       = t.rdv;
        dut_if.wb_data      = t.wb;
        dut_if.rd_dx        = t.rdi;
        dut_if.writes_rf_dx = t.wr;
    endtask

    // Advance one edge; any new X/M entry is compared with the scoreboard head.
    task automatic step();
        logic stalled;
        exp_t e;
        @(posedge clk);
        stalled = dut_if.mem_stall || !n_reset;
        #1;
        if (dut_if.xm_valid && !stalled) begin
            if (sb.size() == 0) begin
                chk("unexpected xm entry", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("xm_result", dut_if.xm_result, e.res);
                chk("xm_rd", 32'(dut_if.xm_rd), 32'(e.rd));
                chk("xm_writes_rf", 32'(dut_if.xm_writes_rf), 32'(e.wr));
                chk("illegal_op", 32'(dut_if.illegal_op), 32'(e.ill));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " xm_valid"}, 32'(dut_if.xm_valid), 32'd0);
        chk({tag, " xm_result"}, dut_if.xm_result, 32'd0);
        chk({tag, " xm_rd"}, 32'(dut_if.xm_rd), 32'd0);
        chk({tag, " xm_writes_rf"}, 32'(dut_if.xm_writes_rf), 32'd0);
        chk({tag, " x_busy"}, 32'(dut_if.x_busy), 32'd0);
        chk({tag, " illegal_op"}, 32'(dut_if.illegal_op), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int edges;
        int busy_cnt;
        int seen;

        // Forwarding rows depend on xm_result left by the row before them.
        vecs.push_back(mk(1, 4'd8, 2'd0, 2'd0, 32'd3, 32'd77, 32'd0, 5'd1, 1, 1, 32'd3, 1, 0));
        vecs.push_back(mk(1, 4'd0, 2'd2, 2'd0, 32'd1, 32'd10, 32'd2, 5'd2, 1, 1, 32'd13, 1, 0));
        vecs.push_back(mk(1, 4'd0, 2'd1, 2'd0, 32'd1, 32'd10, 32'd2, 5'd2, 1, 1, 32'd12, 1, 0));
        vecs.push_back(mk(1, 4'd0, 2'd3, 2'd0, 32'd1, 32'd10, 32'd2, 5'd2, 1, 1, 32'd11, 1, 0));
        vecs.push_back(mk(1, 4'd0, 2'd0, 2'd2, 32'd5, 32'd99, 32'd0, 5'd3, 1, 1, 32'd16, 1, 0));
        vecs.push_back(mk(1, 4'd1, 2'd0, 2'd1, 32'd10, 32'd100, 32'd3, 5'd3, 1, 1, 32'd7, 1, 0));
        vecs.push_back(mk(1, 4'd1, 2'd0, 2'd0, 32'd0, 32'd1, 32'd0, 5'd4, 1, 1,
                          32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk(1, 4'd7, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd5, 1, 1,
                          32'd1, 1, 0));
        vecs.push_back(mk(1, 4'd7, 2'd0, 2'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd5, 1, 1,
                          32'd0, 1, 0));
        vecs.push_back(mk(1, 4'd5, 2'd0, 2'd0, 32'd1, 32'd33, 32'd0, 5'd6, 1, 1, 32'd2, 1, 0));
        vecs.push_back(mk(1, 4'd6, 2'd0, 2'd0, 32'h8000_0000, 32'd31, 32'd0, 5'd6, 1, 1,
                          32'd1, 1, 0));
        vecs.push_back(mk(1, 4'd2, 2'd0, 2'd0, 32'hF0F0, 32'hFF00, 32'd0, 5'd7, 1, 1,
                          32'hF000, 1, 0));
        vecs.push_back(mk(1, 4'd3, 2'd0, 2'd0, 32'hF0F0, 32'hFF00, 32'd0, 5'd7, 1, 1,
                          32'hFFF0, 1, 0));
        vecs.push_back(mk(1, 4'd4, 2'd0, 2'd0, 32'hF0F0, 32'hFF00, 32'd0, 5'd7, 1, 1,
                          32'h0FF0, 1, 0));
        vecs.push_back(mk(1, 4'd15, 2'd0, 2'd0, 32'd5, 32'd5, 32'd0, 5'd12, 1, 1, 32'd0, 0, 1));
        vecs.push_back(mk(1, 4'd0, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd8, 1, 1,
                          32'd1, 1, 0));
        vecs.push_back(mk(1, 4'd0, 2'd0, 2'd0, 32'd20, 32'd22, 32'd0, 5'd9, 0, 1, 32'd42, 0, 0));
`ifndef EXEC_MUL_EN
        vecs.push_back(mk(1, 4'd9, 2'd0, 2'd0, 32'd6, 32'd7, 32'd0, 5'd13, 1, 1, 32'd0, 0, 1));
`endif
        vecs.push_back(mk(0, 4'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 5'd10, 1, 0, 32'd0, 0, 0));

        // Reset state
        n_reset = 1'b0;
        drive(mk(0, 4'd0, 2'd0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0, 32'd0, 0, 0));
        dut_if.bubble    = 1'b0;
        dut_if.mem_stall = 1'b0;
        step();
        step();
        check_zero("reset");
        n_reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            if (vecs[i].ev) push(vecs[i].eres, vecs[i].rdi, vecs[i].ewr, vecs[i].eill);
            step();
            if (!vecs[i].ev) chk("nop xm_valid", 32'(dut_if.xm_valid), 32'd0);
        end

        // Bubble turns a valid ADD into a NOP for one edge, then it completes
        drive(mk(1, 4'd0, 2'd0, 2'd0, 32'd40, 32'd2, 32'd0, 5'd6, 1, 0, 32'd0, 0, 0));
        dut_if.bubble = 1'b1;
        step();
        chk("bubble xm_valid", 32'(dut_if.xm_valid), 32'd0);
        chk("bubble xm_writes_rf", 32'(dut_if.xm_writes_rf), 32'd0);
        dut_if.bubble = 1'b0;
        push(32'd42, 5'd6, 1'b1, 1'b0);
        step();

        // mem_stall holds X/M on a single-cycle op
        drive(mk(1, 4'd0, 2'd0, 2'd0, 32'd100, 32'd23, 32'd0, 5'd9, 1, 0, 32'd0, 0, 0));
        push(32'd123, 5'd9, 1'b1, 1'b0);
        step();
        drive(mk(1, 4'd0, 2'd0, 2'd0, 32'd1, 32'd1, 32'd0, 5'd4, 1, 0, 32'd0, 0, 0));
        dut_if.mem_stall = 1'b1;
        repeat (2) begin
            step();
            chk("stall xm_result", dut_if.xm_result, 32'd123);
            chk("stall xm_rd", 32'(dut_if.xm_rd), 32'd9);
            chk("stall xm_valid", 32'(dut_if.xm_valid), 32'd1);
        end
        dut_if.mem_stall = 1'b0;
        push(32'd2, 5'd4, 1'b1, 1'b0);
        step();

`ifdef EXEC_MUL_EN
        // Full multiply: busy for MUL_CYC cycles, product after MUL_CYC+2 edges
        drive(mk(1, 4'd9, 2'd0, 2'd0, 32'hFFFF_FFFF, 32'd3, 32'd0, 5'd7, 1, 0, 32'd0, 0, 0));
        push(32'hFFFF_FFFD, 5'd7, 1'b1, 1'b0);
        step();
        edges = 1;
        busy_cnt = dut_if.x_busy ? 1 : 0;
        chk("mul accept x_busy", 32'(dut_if.x_busy), 32'd1);
        chk("mul accept xm_valid", 32'(dut_if.xm_valid), 32'd0);
        while (!dut_if.xm_valid && edges < 40) begin
            if (!dut_if.x_busy) dut_if.valid_dx = 1'b0;
            step();
            edges++;
            if (dut_if.x_busy) busy_cnt++;
        end
        chk("mul edges", 32'(edges), 32'd10);
        chk("mul busy cycles", 32'(busy_cnt), 32'd8);
        dut_if.valid_dx = 1'b0;

        // A bubble suppresses the multiply start
        drive(mk(1, 4'd9, 2'd0, 2'd0, 32'd2, 32'd2, 32'd0, 5'd1, 1, 0, 32'd0, 0, 0));
        dut_if.bubble = 1'b1;
        step();
        chk("mul bubble x_busy", 32'(dut_if.x_busy), 32'd0);
        chk("mul bubble xm_valid", 32'(dut_if.xm_valid), 32'd0);
        dut_if.bubble   = 1'b0;
        dut_if.valid_dx = 1'b0;
        step();
        chk("mul bubble no start", 32'(dut_if.x_busy), 32'd0);

        // Stall for 3 cycles at iteration 4; operand A forwarded from wb_data
        drive(mk(1, 4'd9, 2'd1, 2'd0, 32'hDEAD, 32'd7, 32'd5, 5'd3, 1, 0, 32'd0, 0, 0));
        push(32'd35, 5'd3, 1'b1, 1'b0);
        step();
        edges = 1;
        repeat (3) begin
            step();
            edges++;
        end
        dut_if.mem_stall = 1'b1;
        repeat (3) begin
            step();
            edges++;
            chk("mul stall x_busy", 32'(dut_if.x_busy), 32'd1);
            chk("mul stall xm_valid", 32'(dut_if.xm_valid), 32'd0);
        end
        dut_if.mem_stall = 1'b0;
        while (!dut_if.xm_valid && edges < 40) begin
            if (!dut_if.x_busy) dut_if.valid_dx = 1'b0;
            step();
            edges++;
        end
        chk("mul stall edges", 32'(edges), 32'd13);
        dut_if.valid_dx = 1'b0;

        // Reset at iteration 2 aborts the multiply with no write
        drive(mk(1, 4'd9, 2'd0, 2'd0, 32'd2, 32'd3, 32'd0, 5'd11, 1, 0, 32'd0, 0, 0));
        repeat (3) step();
        chk("mul pre-reset x_busy", 32'(dut_if.x_busy), 32'd1);
        n_reset         = 1'b0;
        dut_if.valid_dx = 1'b0;
        step();
        check_zero("mul reset");
        n_reset = 1'b1;
        seen = 0;
        repeat (12) begin
            step();
            if (dut_if.xm_valid || dut_if.x_busy) seen++;
        end
        chk("mul reset no write", 32'(seen), 32'd0);
`endif

        // Reset after a completed op clears X/M
        drive(mk(1, 4'd0, 2'd0, 2'd0, 32'd9, 32'd9, 32'd0, 5'd15, 1, 0, 32'd0, 0, 0));
        push(32'd18, 5'd15, 1'b1, 1'b0);
        step();
        n_reset = 1'b0;
        step();
        check_zero("late reset");
        n_reset         = 1'b1;
        dut_if.valid_dx = 1'b0;
        seen = 0;
        repeat (4) begin
            step();
            if (dut_if.xm_valid) seen++;
        end
        chk("late reset idle", 32'(seen), 32'd0);

        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
